// File: rtl/temp_monitor_mc.sv
// Multi-channel temperature monitor.
// Keeps the latest sample for each channel. For each channel it applies fan
// hysteresis and a persistence-filtered over-temperature alarm. It also
// reports the hottest channel and drives a sticky overheat LED.
module temp_monitor_mc #(
   parameter int W            = 10,
   parameter int CH           = 4,
   parameter int FAN_ON_TH    = 500,
   parameter int FAN_OFF_TH   = 450,
   parameter int ALARM_TH     = 800,
   parameter int ALARM_CLR_TH = 750,
   parameter int PERSIST      = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [W-1:0]                          temp_in,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] temp_ch,
   input  logic                                  temp_valid,
   input  logic                                  led_clr,
   output logic [W-1:0]                          temp_out,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] max_ch,
   output logic [CH-1:0]                         ch_alarm,
   output logic                                  alarm,
   output logic                                  fan_on,
   output logic                                  overheat_led,
   output logic                                  err_ch
);

   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW = $clog2(PERSIST + 1);

   localparam logic [CW:0]   CH_LIM    = (CW + 1)'(CH);
   localparam logic [PW-1:0] PMAX      = PW'(PERSIST);
   localparam logic [W-1:0]  FAN_ON_V  = W'(FAN_ON_TH);
   localparam logic [W-1:0]  FAN_OFF_V = W'(FAN_OFF_TH);
   localparam logic [W-1:0]  ALARM_V   = W'(ALARM_TH);
   localparam logic [W-1:0]  ALM_CLR_V = W'(ALARM_CLR_TH);

   logic [W-1:0]  val_q [CH];
   logic [W-1:0]  val_d [CH];
   logic [PW-1:0] cnt_q [CH];
   logic [PW-1:0] cnt_d [CH];
   logic [CH-1:0] fan_q, fan_d;
   logic [CH-1:0] alm_q, alm_d;
   logic          led_q, led_d;
   logic          err_q, err_d;
   logic [W-1:0]  tout_q, tout_d;
   logic [CW-1:0] mch_q, mch_d;

   logic in_range, acc, hot, fan_set, fan_clr, alm_clr, rise;

   // Per-channel next state: only the addressed channel moves on an accepted sample
   always_comb begin
      in_range = ({1'b0, temp_ch} < CH_LIM);
      acc      = temp_valid & in_range;
      hot      = (temp_in >= ALARM_V);
      fan_set  = (temp_in >= FAN_ON_V);
      fan_clr  = (temp_in < FAN_OFF_V);
      alm_clr  = (temp_in < ALM_CLR_V);
      fan_d    = fan_q;
      alm_d    = alm_q;
      for (int c = 0; c < CH; c++) begin
         val_d[c] = val_q[c];
         cnt_d[c] = cnt_q[c];
         if (acc && (temp_ch == CW'(c))) begin
            val_d[c] = temp_in;
            if (fan_set) begin
               fan_d[c] = 1'b1;
            end else if (fan_clr) begin
               fan_d[c] = 1'b0;
            end
            if (hot) begin
               cnt_d[c] = (cnt_q[c] == PMAX) ? PMAX : cnt_q[c] + 1'b1;
            end else begin
               cnt_d[c] = '0;
            end
            // A sample in the band between clear and alarm thresholds zeroes the run but keeps the alarm
            if (hot && (cnt_d[c] == PMAX)) begin
               alm_d[c] = 1'b1;
            end else if (alm_clr) begin
               alm_d[c] = 1'b0;
            end
         end
      end
      // A rising alarm wins over a same-edge clear request
      rise = |(alm_d & ~alm_q);
      if (rise) begin
         led_d = 1'b1;
      end else if (led_clr && (alm_d == '0)) begin
         led_d = 1'b0;
      end else begin
         led_d = led_q;
      end
      err_d = temp_valid & ~in_range;
   end

   // Hottest stored channel; strict compare keeps ties on the lowest index
   always_comb begin
      tout_d = val_q[0];
      mch_d  = '0;
      for (int c = 1; c < CH; c++) begin
         if (val_q[c] > tout_d) begin
            tout_d = val_q[c];
            mch_d  = CW'(c);
         end
      end
   end

   // State registers; the asynchronous reset clears every register, so a partial persistence run is lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            val_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         fan_q  <= '0;
         alm_q  <= '0;
         led_q  <= 1'b0;
         err_q  <= 1'b0;
         tout_q <= '0;
         mch_q  <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            val_q[c] <= val_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         fan_q  <= fan_d;
         alm_q  <= alm_d;
         led_q  <= led_d;
         err_q  <= err_d;
         tout_q <= tout_d;
         mch_q  <= mch_d;
      end
   end

   assign temp_out     = tout_q;
   assign max_ch       = mch_q;
   assign ch_alarm     = alm_q;
   assign alarm        = |alm_q;
   assign fan_on       = |fan_q;
   assign overheat_led = led_q;
   assign err_ch       = err_q;

endmodule

// File: tb/tb_temp_monitor_mc.sv
// Bench for temp_monitor_mc. A 4-channel and a 3-channel instance share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_temp_monitor_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] temp_in = '0;
   logic [1:0] temp_ch = '0;
   logic       temp_valid = 1'b0;
   logic       led_clr = 1'b0;

   logic [9:0] o4_temp_out, o3_temp_out;
   logic [1:0] o4_max_ch, o3_max_ch;
   logic [3:0] o4_ch_alarm;
   logic [2:0] o3_ch_alarm;
   logic       o4_alarm, o3_alarm, o4_fan_on, o3_fan_on;
   logic       o4_led, o3_led, o4_err, o3_err;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   temp_monitor_mc #(.CH(4)) dut4 (
      .clk(clk), .rst(rst), .temp_in(temp_in), .temp_ch(temp_ch),
      .temp_valid(temp_valid), .led_clr(led_clr), .temp_out(o4_temp_out),
      .max_ch(o4_max_ch), .ch_alarm(o4_ch_alarm), .alarm(o4_alarm),
      .fan_on(o4_fan_on), .overheat_led(o4_led), .err_ch(o4_err));

   temp_monitor_mc #(.CH(3)) dut3 (
      .clk(clk), .rst(rst), .temp_in(temp_in), .temp_ch(temp_ch),
      .temp_valid(temp_valid), .led_clr(led_clr), .temp_out(o3_temp_out),
      .max_ch(o3_max_ch), .ch_alarm(o3_ch_alarm), .alarm(o3_alarm),
      .fan_on(o3_fan_on), .overheat_led(o3_led), .err_ch(o3_err));

   // Behavioural model: index 0 is the 4-channel instance, 1 the 3-channel one
   int nch [2] = '{4, 3};
   int val [2][4];
   int run [2][4];      // unsaturated length of the current hot run
   bit fan [2][4];
   bit alm [2][4];
   bit led [2];
   bit err [2];
   int tout [2];
   int mch [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
               val[k][c] = 0; run[k][c] = 0; fan[k][c] = 0; alm[k][c] = 0;
            end
            led[k] = 0; err[k] = 0; tout[k] = 0; mch[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            int best, bi, s, c;
            bit rise, any;
            best = val[k][0]; bi = 0;
            for (int j = 1; j < nch[k]; j++)
               if (val[k][j] > best) begin best = val[k][j]; bi = j; end
            rise = 0;
            err[k] = temp_valid && (int'(temp_ch) >= nch[k]);
            if (temp_valid && int'(temp_ch) < nch[k]) begin
               c = int'(temp_ch);
               s = int'(temp_in);
               val[k][c] = s;
               if (s >= 500) fan[k][c] = 1;
               else if (s < 450) fan[k][c] = 0;
               if (s >= 800) run[k][c]++;
               else run[k][c] = 0;
               if (run[k][c] >= 3) begin
                  if (!alm[k][c]) rise = 1;
                  alm[k][c] = 1;
               end else if (s < 750) begin
                  alm[k][c] = 0;
               end
            end
            any = 0;
            for (int j = 0; j < nch[k]; j++) any |= alm[k][j];
            if (rise) led[k] = 1;
            else if (led_clr && !any) led[k] = 0;
            tout[k] = best;
            mch[k] = bi;
         end
      end
   end

   task automatic cmp(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
      end
   endtask

   function automatic int exp_alm_vec(input int k);
      int v = 0;
      for (int j = 0; j < nch[k]; j++) if (alm[k][j]) v |= (1 << j);
      return v;
   endfunction

   function automatic int exp_or(input int k, input bit is_fan);
      int v = 0;
      for (int j = 0; j < nch[k]; j++) v |= is_fan ? fan[k][j] : alm[k][j];
      return v;
   endfunction

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("temp_out", 0, int'(o4_temp_out), tout[0]);
         cmp("max_ch",   0, int'(o4_max_ch),   mch[0]);
         cmp("ch_alarm", 0, int'(o4_ch_alarm), exp_alm_vec(0));
         cmp("alarm",    0, int'(o4_alarm),    exp_or(0, 0));
         cmp("fan_on",   0, int'(o4_fan_on),   exp_or(0, 1));
         cmp("led",      0, int'(o4_led),      int'(led[0]));
         cmp("err_ch",   0, int'(o4_err),      int'(err[0]));
         cmp("temp_out", 1, int'(o3_temp_out), tout[1]);
         cmp("max_ch",   1, int'(o3_max_ch),   mch[1]);
         cmp("ch_alarm", 1, int'(o3_ch_alarm), exp_alm_vec(1));
         cmp("alarm",    1, int'(o3_alarm),    exp_or(1, 0));
         cmp("fan_on",   1, int'(o3_fan_on),   exp_or(1, 1));
         cmp("led",      1, int'(o3_led),      int'(led[1]));
         cmp("err_ch",   1, int'(o3_err),      int'(err[1]));
      end
   end

   // Drive one cycle of inputs, return 1ns after the edge that samples them
   task automatic drive(input bit v, input int ch, input int t, input bit clr);
      temp_valid = v;
      temp_ch    = 2'(ch);
      temp_in    = 10'(t);
      led_clr    = clr;
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
      led_clr    = 1'b0;
   endtask

   task automatic send(input int ch, input int t);
      drive(1'b1, ch, t, 1'b0);
   endtask

   int sv_tout, sv_fan, sv_alm;

   initial begin
      #2 rst = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cmp("lit_reset_temp_out", 0, int'(o4_temp_out), 0);
      cmp("lit_reset_alarm",    0, int'(o4_alarm), 0);
      cmp("lit_reset_led",      0, int'(o4_led), 0);
      cmp("lit_reset_fan",      0, int'(o4_fan_on), 0);
      rst = 1'b0;

      // Basic max tracking and fan request
      send(0, 400);
      send(1, 550);
      cmp("lit_fan_after_550", 0, int'(o4_fan_on), 1);
      send(2, 300);
      cmp("lit_temp_out_550", 0, int'(o4_temp_out), 550);
      cmp("lit_max_ch_1",     0, int'(o4_max_ch), 1);
      cmp("lit_alarm_0",      0, int'(o4_alarm), 0);

      // Fan hysteresis on ch1
      send(1, 550); cmp("lit_hyst_550", 0, int'(o4_fan_on), 1);
      send(1, 470); cmp("lit_hyst_470", 0, int'(o4_fan_on), 1);
      send(1, 440); cmp("lit_hyst_440", 0, int'(o4_fan_on), 0);
      send(1, 480); cmp("lit_hyst_480", 0, int'(o4_fan_on), 0);

      // Persistence on ch2 with ch0 interleaved
      send(2, 900); cmp("lit_pers_1", 0, int'(o4_alarm), 0);
      send(0, 100);
      send(2, 900); cmp("lit_pers_2", 0, int'(o4_alarm), 0);
      send(0, 100);
      send(2, 780); cmp("lit_pers_780", 0, int'(o4_alarm), 0);
      send(2, 900); cmp("lit_pers_4", 0, int'(o4_alarm), 0);
      send(0, 100);
      send(2, 900); cmp("lit_pers_5", 0, int'(o4_alarm), 0);
      cmp("lit_pers_5_led", 0, int'(o4_led), 0);
      send(2, 900);
      cmp("lit_pers_6_alarm", 0, int'(o4_alarm), 1);
      cmp("lit_pers_6_vec",   0, int'(o4_ch_alarm), 4);
      cmp("lit_pers_6_led",   0, int'(o4_led), 1);

      // Alarm clear and sticky LED
      send(2, 760); cmp("lit_clr_760", 0, int'(o4_alarm), 1);
      drive(1'b0, 0, 0, 1'b1);
      cmp("lit_clr_ignored", 0, int'(o4_led), 1);
      send(2, 700);
      cmp("lit_clr_700_alarm", 0, int'(o4_alarm), 0);
      cmp("lit_clr_700_led",   0, int'(o4_led), 1);
      drive(1'b0, 0, 0, 1'b1);
      cmp("lit_led_cleared", 0, int'(o4_led), 0);

      // Set beats clear on the same edge
      send(2, 900);
      send(2, 900);
      drive(1'b1, 2, 900, 1'b1);
      cmp("lit_set_beats_clr", 0, int'(o4_led), 1);

      // Out-of-range channel on the 3-channel instance
      drive(1'b0, 0, 0, 1'b0);
      drive(1'b0, 0, 0, 1'b0);
      sv_tout = int'(o3_temp_out);
      sv_fan  = int'(o3_fan_on);
      sv_alm  = int'(o3_alarm);
      send(3, 1000);
      cmp("lit_err_pulse", 1, int'(o3_err), 1);
      drive(1'b0, 0, 0, 1'b0);
      cmp("lit_err_gone",  1, int'(o3_err), 0);
      cmp("lit_err_tout",  1, int'(o3_temp_out), sv_tout);
      cmp("lit_err_fan",   1, int'(o3_fan_on), sv_fan);
      cmp("lit_err_alarm", 1, int'(o3_alarm), sv_alm);

      // Reset during a partial persistence run
      send(1, 900);
      send(1, 900);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send(1, 900);
      cmp("lit_rst_run_3", 1, int'(o3_alarm), 0);
      cmp("lit_rst_run_4", 0, int'(o4_alarm), 0);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         int t;
         case ($urandom_range(0, 5))
            0: t = $urandom_range(0, 1023);
            1: t = $urandom_range(800, 1023);
            2: t = $urandom_range(750, 799);
            3: t = $urandom_range(450, 499);
            4: t = $urandom_range(0, 449);
            default: t = 1023;
         endcase
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
         end else begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), t,
                  $urandom_range(0, 7) == 0);
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
